// File: rtl/axi_rd_pkg.sv
// ----------------------------------------------------------------------------
// axi_rd_pkg
// Shared definitions for the AXI4 burst read master:
//   - rd_state_e         : controller state encoding
//   - AXI_BURST_INCR     : ARBURST encoding for incrementing bursts
//   - AXI_RESP_*         : RRESP encodings
//   - AXI_ARPROT_DEFAULT : privileged, non-secure, instruction access
//   - resp_is_err()      : true for SLVERR/DECERR
// ----------------------------------------------------------------------------
package axi_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY      = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY    = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR    = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR    = 2'b11;
  localparam logic [2:0] AXI_ARPROT_DEFAULT = 3'b111;

  // SLVERR and DECERR both have the MSB set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] rresp);
    return rresp[1];
  endfunction

endpackage

// File: rtl/axi_rd_linebuf.sv
// ----------------------------------------------------------------------------
// axi_rd_linebuf
// Line buffer of DEPTH entries x DW bits with synchronous clear, one indexed
// write port and a flat read of the whole line.
// Ports:
//   ACLK, ARESETn : clock, synchronous active-low reset (clears all entries)
//   clr           : clear every entry to zero
//   wr_en/wr_idx/wr_data : write one entry
//   rd_line       : entry i at bits [i*DW +: DW]
// The whole line is read at once, so entries are plain registers rather than
// a RAM array.
// ----------------------------------------------------------------------------
module axi_rd_linebuf #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [DW-1:0]         wr_data,
  output logic [DW*DEPTH-1:0]   rd_line
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DW-1:0] entry_reg;

      always_ff @(posedge ACLK) begin
        if (!ARESETn || clr) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_idx == IW'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign rd_line[gi*DW +: DW] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_burst_rd_master.sv
// ----------------------------------------------------------------------------
// axi_burst_rd_master
// AXI4 read master: one INCR burst per request, beats gathered into a line
// buffer, whole line returned with an error flag.
// Ports:
//   ACLK, ARESETn             : clock, synchronous active-low reset
//   req_valid/req_ready       : request handshake; req_addr, req_len (beats-1)
//   resp_valid/resp_ready     : line handshake; resp_line, resp_err
//   AR* / R*                  : AXI4 read address and read data channels
// Optional feature: define RD_TIMEOUT_EN to add a watchdog. A stalled burst is
// then reported with resp_err=1 after TIMEOUT idle cycles in DATA, and the
// remaining beats are drained (DRAIN state) before a new request is taken.
// Without it a stalled slave stalls the master indefinitely.
// ----------------------------------------------------------------------------
module axi_burst_rd_master
  import axi_rd_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 64,
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [AW-1:0]                req_addr,
  input  logic [$clog2(MAX_BEATS)-1:0] req_len,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DW*MAX_BEATS-1:0]      resp_line,
  output logic                         resp_err,
  output logic                         ARVALID,
  input  logic                         ARREADY,
  output logic [AW-1:0]                ARADDR,
  output logic [7:0]                   ARLEN,
  output logic [2:0]                   ARSIZE,
  output logic [1:0]                   ARBURST,
  output logic [2:0]                   ARPROT,
  input  logic                         RVALID,
  output logic                         RREADY,
  input  logic [DW-1:0]                RDATA,
  input  logic [1:0]                   RRESP,
  input  logic                         RLAST
);

  localparam int unsigned LW         = $clog2(MAX_BEATS);
  // Nine bits so that over-long bursts (up to 256 beats) never wrap back
  // into the valid index range; saturates beyond that.
  localparam int unsigned CW         = 9;
  localparam int unsigned ARSIZE_VAL = $clog2(DW/8);

  rd_state_e        state_reg, state_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [LW-1:0]    len_reg, len_next;
  logic [CW-1:0]    beat_cnt_reg, beat_cnt_next;
  logic             err_reg, err_next;
  logic             buf_clr;
  logic             buf_we;

`ifdef RD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    timer_reg, timer_next;
  logic             drain_reg, drain_next;
`else
  logic [31:0]      unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  logic unused_rresp_lsb;
  assign unused_rresp_lsb = RRESP[0];

  // All AXI and handshake outputs come straight from registers.
  assign req_ready  = (state_reg == ST_IDLE);
  assign ARVALID    = (state_reg == ST_ADDR);
  assign RREADY     = (state_reg == ST_DATA) || (state_reg == ST_DRAIN);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_err   = err_reg;
  assign ARADDR     = addr_reg;
  assign ARLEN      = 8'(len_reg);
  assign ARSIZE     = 3'(ARSIZE_VAL);
  assign ARBURST    = AXI_BURST_INCR;
  assign ARPROT     = AXI_ARPROT_DEFAULT;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
`ifdef RD_TIMEOUT_EN
      timer_reg    <= '0;
      drain_reg    <= 1'b0;
`endif
    end else begin
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
`ifdef RD_TIMEOUT_EN
      timer_reg    <= timer_next;
      drain_reg    <= drain_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    buf_clr       = 1'b0;
    buf_we        = 1'b0;
`ifdef RD_TIMEOUT_EN
    drain_next    = drain_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          addr_next     = req_addr;
          len_next      = req_len;
          beat_cnt_next = '0;
          err_next      = 1'b0;
          buf_clr       = 1'b1;
          state_next    = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (ARREADY) begin
          state_next = ST_DATA;
        end
      end

      ST_DATA: begin
        if (RVALID) begin
          // Beats past the requested length are consumed but not stored.
          buf_we = (beat_cnt_reg <= CW'(len_reg));
          if (beat_cnt_reg != {CW{1'b1}}) begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
          if (resp_is_err(RRESP)) begin
            err_next = 1'b1;
          end
          if (RLAST) begin
            if (beat_cnt_reg != CW'(len_reg)) begin
              err_next = 1'b1;
            end
            state_next = ST_RESP;
          end
        end
`ifdef RD_TIMEOUT_EN
        else if (timer_reg == TW'(TIMEOUT)) begin
          err_next   = 1'b1;
          drain_next = 1'b1;
          state_next = ST_RESP;
        end
`endif
      end

      ST_RESP: begin
        if (resp_ready) begin
`ifdef RD_TIMEOUT_EN
          state_next = drain_reg ? ST_DRAIN : ST_IDLE;
          drain_next = 1'b0;
`else
          state_next = ST_IDLE;
`endif
        end
      end

`ifdef RD_TIMEOUT_EN
      ST_DRAIN: begin
        if (RVALID && RLAST) begin
          state_next = ST_IDLE;
        end
      end
`endif

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef RD_TIMEOUT_EN
  // Idle-cycle watchdog: counts while waiting on AR or R, restarts on every
  // handshake, saturates at TIMEOUT (in ADDR the AR simply stays up).
  always_comb begin
    timer_next = '0;
    if ((state_reg == ST_ADDR) || (state_reg == ST_DATA)) begin
      if ((ARVALID && ARREADY) || (RREADY && RVALID)) begin
        timer_next = '0;
      end else if (timer_reg != TW'(TIMEOUT)) begin
        timer_next = timer_reg + 1'b1;
      end else begin
        timer_next = timer_reg;
      end
    end
  end
`endif

  axi_rd_linebuf #(
    .DW    (DW),
    .DEPTH (MAX_BEATS),
    .IW    (LW)
  ) u_linebuf (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clr     (buf_clr),
    .wr_en   (buf_we),
    .wr_idx  (beat_cnt_reg[LW-1:0]),
    .wr_data (RDATA),
    .rd_line (resp_line)
  );

endmodule

// File: tb/tb_axi_burst_rd_master.sv
// ----------------------------------------------------------------------------
// tb_axi_burst_rd_master
// Directed bench for axi_burst_rd_master (AW=32, DW=64, MAX_BEATS=8,
// TIMEOUT=16). Expected lines/error flags are queued when a request is issued
// and compared when the line is returned. Watchdog checks are compiled in
// when RD_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_axi_burst_rd_master;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MB   = 8;
  localparam int LW   = 3;
  localparam int LINE = DW * MB;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AW-1:0]    req_addr = '0;
  logic [LW-1:0]    req_len = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [LINE-1:0]  resp_line;
  logic             resp_err;
  logic             ARVALID;
  logic             ARREADY = 1'b0;
  logic [AW-1:0]    ARADDR;
  logic [7:0]       ARLEN;
  logic [2:0]       ARSIZE;
  logic [1:0]       ARBURST;
  logic [2:0]       ARPROT;
  logic             RVALID = 1'b0;
  logic             RREADY;
  logic [DW-1:0]    RDATA = '0;
  logic [1:0]       RRESP = 2'b00;
  logic             RLAST = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_burst_rd_master #(
    .AW(AW), .DW(DW), .MAX_BEATS(MB), .TIMEOUT(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_line(resp_line), .resp_err(resp_err),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  typedef struct {
    logic [LINE-1:0] line;
    logic            err;
  } exp_t;

  exp_t            sb[$];
  int              tests = 0;
  int              fails = 0;
  logic [AW-1:0]   cur_addr;
  logic [LINE-1:0] exp_line;
  int              txn = 0;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a request (DUT must be idle) and queue the expected result.
  task automatic request(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input logic [LINE-1:0] line, input logic err);
    exp_t e;
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_idle", req_ready, 1);
    e.line = line;
    e.err  = err;
    sb.push_back(e);
    cur_addr  = addr;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    tick();
    req_valid = 1'b0;
    chk("arvalid_next_cycle", ARVALID, 1);
    chk("araddr", ARADDR, addr);
    chk("arlen", ARLEN, 8'(len));
    chk("arsize", ARSIZE, 3'd3);
    chk("arburst", ARBURST, 2'b01);
    chk("arprot", ARPROT, 3'b111);
    chk("req_ready_busy", req_ready, 0);
  endtask

  // Hold ARREADY low for 'delay' cycles, then accept the address.
  task automatic addr_phase(input int delay);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("arvalid_hold", ARVALID, 1);
      chk("araddr_hold", ARADDR, cur_addr);
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk("arvalid_drop", ARVALID, 0);
    chk("rready_data", RREADY, 1);
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [1:0] r, input logic last, input int gap);
    RVALID = 1'b1;
    RDATA  = d;
    RRESP  = r;
    RLAST  = last;
    tick();
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RRESP  = 2'b00;
    repeat (gap) tick();
  endtask

  // Wait (bounded) for the line, compare with the scoreboard head, optionally
  // stall resp_ready for 'hold' cycles, then take the line.
  task automatic collect(input int hold, input logic exp_idle_after);
    exp_t e;
    int n;
    n = 0;
    while (resp_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("resp_valid_seen", resp_valid, 1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: observed response expected none");
    end else begin
      e = sb.pop_front();
      chk("resp_line", resp_line, e.line);
      chk("resp_err", resp_err, e.err);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("resp_valid_stall", resp_valid, 1);
        chk("resp_line_stall", resp_line, e.line);
        chk("resp_err_stall", resp_err, e.err);
        chk("req_ready_resp", req_ready, 0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("resp_valid_clear", resp_valid, 0);
      chk("req_ready_after", req_ready, exp_idle_after);
      txn++;
      $display("[TB] txn %0d addr=%08h err=%0b line=%0h", txn, cur_addr, resp_err, resp_line);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_arvalid"}, ARVALID, 0);
    chk({tag, "_rready"}, RREADY, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_resp_line"}, resp_line, '0);
  endtask

  initial begin
    int n;
    // ---- reset ----
    ARESETn = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    ARESETn = 1'b1;
    tick();

    // ---- single beat, immediate ARREADY ----
    exp_line = '0;
    exp_line[0 +: DW] = 64'hDEAD_BEEF_0123_4567;
    request(32'h8000_0000, 3'd0, exp_line, 1'b0);
    addr_phase(0);
    beat(64'hDEAD_BEEF_0123_4567, 2'b00, 1'b1, 0);
    chk("resp_latency_1", resp_valid, 1);
    collect(0, 1'b1);

    // ---- 8 beats, ARREADY delayed, gapped R, one EXOKAY beat ----
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line[i*DW +: DW] = 64'(i);
    request(32'h0000_1000, 3'd7, exp_line, 1'b0);
    addr_phase(3);
    for (int i = 0; i < 8; i++) begin
      beat(64'(i), (i == 5) ? 2'b01 : 2'b00, (i == 7), (i == 7) ? 0 : 1);
      if (i < 7) chk("no_early_resp", resp_valid, 0);
    end
    chk("resp_latency_8", resp_valid, 1);
    collect(0, 1'b1);

    // ---- SLVERR on beat 2, resp_ready stalled 10 cycles ----
    exp_line = '0;
    for (int i = 0; i < 4; i++) exp_line[i*DW +: DW] = 64'hA0A0_0000_0000_0000 | 64'(i);
    request(32'h0000_2000, 3'd3, exp_line, 1'b1);
    addr_phase(1);
    for (int i = 0; i < 4; i++)
      beat(64'hA0A0_0000_0000_0000 | 64'(i), (i == 2) ? 2'b10 : 2'b00, (i == 3), 0);
    collect(10, 1'b1);

    // ---- DECERR on last beat of a 2-beat burst ----
    exp_line = '0;
    exp_line[0 +: DW]  = 64'h5555_0000_0000_0001;
    exp_line[DW +: DW] = 64'h5555_0000_0000_0002;
    request(32'h0000_2800, 3'd1, exp_line, 1'b1);
    addr_phase(0);
    beat(64'h5555_0000_0000_0001, 2'b00, 1'b0, 0);
    beat(64'h5555_0000_0000_0002, 2'b11, 1'b1, 0);
    collect(0, 1'b1);

    // ---- early RLAST: len=3, RLAST on beat 1 ----
    exp_line = '0;
    exp_line[0 +: DW]  = 64'hB0;
    exp_line[DW +: DW] = 64'hB1;
    request(32'h0000_3000, 3'd3, exp_line, 1'b1);
    addr_phase(0);
    beat(64'hB0, 2'b00, 1'b0, 0);
    beat(64'hB1, 2'b00, 1'b1, 0);
    chk("early_last_resp", resp_valid, 1);
    collect(0, 1'b1);

    // ---- late RLAST: len=1, 3 beats, third dropped ----
    exp_line = '0;
    exp_line[0 +: DW]  = 64'hC0;
    exp_line[DW +: DW] = 64'hC1;
    request(32'h0000_4000, 3'd1, exp_line, 1'b1);
    addr_phase(0);
    beat(64'hC0, 2'b00, 1'b0, 0);
    beat(64'hC1, 2'b00, 1'b0, 0);
    chk("extra_beat_rready", RREADY, 1);
    beat(64'hC2, 2'b00, 1'b1, 0);
    collect(0, 1'b1);

    // ---- reset in the middle of DATA ----
    exp_line = '0;
    request(32'h0000_5000, 3'd3, exp_line, 1'b0);
    addr_phase(0);
    beat(64'hD0, 2'b00, 1'b0, 0);
    ARESETn = 1'b0;
    tick();
    check_reset_outputs("midreset");
    ARESETn = 1'b1;
    sb.delete();  // burst abandoned, no line will be returned
    tick();

    // ---- recovery after reset ----
    exp_line = '0;
    exp_line[0 +: DW]  = 64'hE0;
    exp_line[DW +: DW] = 64'hE1;
    request(32'h0000_6000, 3'd1, exp_line, 1'b0);
    addr_phase(0);
    beat(64'hE0, 2'b00, 1'b0, 0);
    beat(64'hE1, 2'b00, 1'b1, 0);
    collect(0, 1'b1);

    // ---- slave stops after 2 of 4 beats ----
    exp_line = '0;
    exp_line[0 +: DW]  = 64'hF0;
    exp_line[DW +: DW] = 64'hF1;
`ifdef RD_TIMEOUT_EN
    request(32'h0000_7000, 3'd3, exp_line, 1'b1);
    addr_phase(0);
    beat(64'hF0, 2'b00, 1'b0, 0);
    beat(64'hF1, 2'b00, 1'b0, 0);
    n = 0;
    while (resp_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_latency", (n >= 16 && n <= 17), 1);
    collect(0, 1'b0);
    chk("drain_rready", RREADY, 1);
    beat(64'hF2, 2'b00, 1'b0, 0);
    chk("drain_req_ready", req_ready, 0);
    beat(64'hF3, 2'b00, 1'b1, 0);
    chk("drain_done_idle", req_ready, 1);
    chk("drain_no_resp", resp_valid, 0);
`else
    exp_line[2*DW +: DW] = 64'hF2;
    exp_line[3*DW +: DW] = 64'hF3;
    request(32'h0000_7000, 3'd3, exp_line, 1'b0);
    addr_phase(0);
    beat(64'hF0, 2'b00, 1'b0, 0);
    beat(64'hF1, 2'b00, 1'b0, 0);
    repeat (40) tick();
    chk("stall_no_resp", resp_valid, 0);
    chk("stall_rready", RREADY, 1);
    beat(64'hF2, 2'b00, 1'b0, 0);
    beat(64'hF3, 2'b00, 1'b1, 0);
    collect(0, 1'b1);
`endif

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
